// File: rtl/fifo_drain_ctrl_if.sv
// Byte-FIFO drain controller: 32-bit output stream bundle.
// The master drives data/keep/last/valid and the slave returns ready.
interface fifo_drain_ctrl_if;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;

    modport master (
        output m_tdata,
        output m_tkeep,
        output m_tlast,
        output m_tvalid,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tkeep,
        input  m_tlast,
        input  m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains a byte-wide FIFO into 32-bit little-endian stream words.
// A burst starts when the FIFO is non-empty, en is high and a synchronized
// overrun or write-idle timeout is seen. A burst ends on the word that fills
// BURST_WORDS, or on the word that empties the FIFO. A final partial word
// carries zeroed unfilled lanes and cleared keep bits.
module fifo_drain_ctrl #(
    parameter int BURST_WORDS = 16,
    parameter int FIFO_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    output logic                  fifo_rinc,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    input  logic                  fifo_overrun,
    input  logic                  fifo_tout,
    output logic                  busy,
    output logic                  done,
    fifo_drain_ctrl_if.master     m_axis
);

    localparam logic [7:0] LAST_WORD = 8'(BURST_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAP  = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [1:0]  byte_idx_q,  byte_idx_d;
    logic [7:0]  word_cnt_q,  word_cnt_d;
    logic [31:0] tdata_q,     tdata_d;
    logic [3:0]  tkeep_q,     tkeep_d;
    logic        tlast_q,     tlast_d;
    logic        tvalid_q,    tvalid_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [1:0]  ovr_sync_q,  ovr_sync_d;
    logic [1:0]  tout_sync_q, tout_sync_d;

    logic ovr_s;
    logic tout_s;

    assign ovr_s  = ovr_sync_q[1];
    assign tout_s = tout_sync_q[1];

    // The read strobe is decoded from the state flop and the live empty flag so
    // that it can never coincide with an empty FIFO, even for one cycle.
    assign fifo_rinc = (state_q == ST_READ) && !fifo_rempty;

    assign m_axis.m_tdata  = tdata_q;
    assign m_axis.m_tkeep  = tkeep_q;
    assign m_axis.m_tlast  = tlast_q;
    assign m_axis.m_tvalid = tvalid_q;
    assign busy            = busy_q;
    assign done            = done_q;

    // Next-state and next-output computation for synchronizers and drain FSM.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        done_d      = 1'b0;
        ovr_sync_d  = {ovr_sync_q[0], fifo_overrun};
        tout_sync_d = {tout_sync_q[0], fifo_tout};

        case (state_q)
            ST_IDLE: begin
                if (en && !fifo_rempty && (ovr_s || tout_s)) begin
                    state_d    = ST_READ;
                    byte_idx_d = 2'd0;
                    word_cnt_d = 8'd0;
                    tdata_d    = 32'd0;
                    tkeep_d    = 4'd0;
                    tlast_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!fifo_rempty) begin
                    state_d = ST_CAP;
                end else if (byte_idx_q != 2'd0) begin
                    // FIFO ran dry mid-word: ship what we have as the last word.
                    state_d  = ST_SEND;
                    tlast_d  = 1'b1;
                    tvalid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAP: begin
                tdata_d[{byte_idx_q, 3'b000} +: FIFO_WIDTH] = fifo_rdata;
                tkeep_d[byte_idx_q] = 1'b1;
                if (byte_idx_q == 2'd3) begin
                    state_d  = ST_SEND;
                    tvalid_d = 1'b1;
                    tlast_d  = (word_cnt_q == LAST_WORD) || fifo_rempty;
                end else begin
                    state_d    = ST_READ;
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
            ST_SEND: begin
                if (tvalid_q && m_axis.m_tready) begin
                    tvalid_d = 1'b0;
                    if (tlast_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        tlast_d = 1'b0;
                    end else begin
                        state_d    = ST_READ;
                        word_cnt_d = word_cnt_q + 8'd1;
                        tdata_d    = 32'd0;
                        tkeep_d    = 4'd0;
                        byte_idx_d = 2'd0;
                        tlast_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 2'd0;
            word_cnt_q  <= 8'd0;
            tdata_q     <= 32'd0;
            tkeep_q     <= 4'd0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_sync_q  <= 2'd0;
            tout_sync_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovr_sync_q  <= ovr_sync_d;
            tout_sync_q <= tout_sync_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Testbench for fifo_drain_ctrl (BURST_WORDS=2): byte FIFO model, stream
// monitor and a word/burst reference model built from the FIFO contents.
module tb_fifo_drain_ctrl;

    localparam int BW = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic       fifo_rinc;
    logic [7:0] fifo_rdata = 8'd0;
    logic       fifo_rempty;
    logic       fifo_overrun;
    logic       fifo_tout;
    logic       busy;
    logic       done;
    logic       push_en = 1'b0;
    logic [7:0] push_byte = 8'd0;

    logic [7:0] fifo_q[$];
    int         fifo_cnt = 0;
    beat_t      got[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic  stall_prev = 1'b0;
    beat_t stall_val;
    logic  last_prev = 1'b0;

    fifo_drain_ctrl_if axis ();

    fifo_drain_ctrl #(.BURST_WORDS(BW), .FIFO_WIDTH(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .fifo_rinc    (fifo_rinc),
        .fifo_rdata   (fifo_rdata),
        .fifo_rempty  (fifo_rempty),
        .fifo_overrun (fifo_overrun),
        .fifo_tout    (fifo_tout),
        .busy         (busy),
        .done         (done),
        .m_axis       (axis)
    );

    always #5 clk = ~clk;

    assign fifo_rempty = (fifo_cnt == 0);

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Registered-read byte FIFO: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        logic [7:0] b;
        if (fifo_rinc && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            fifo_rdata <= b;
        end
        if (push_en) fifo_q.push_back(push_byte);
        fifo_cnt <= fifo_q.size();
    end

    // Stream monitor: collects accepted words and checks protocol rules.
    always @(negedge clk) begin
        logic hs;
        if (!resetn) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (fifo_rinc) chk("rinc_while_empty", 64'(fifo_rempty), 64'(0));
            if (axis.m_tvalid) begin
                chk("rinc_in_send", 64'(fifo_rinc), 64'(0));
                chk("busy_in_send", 64'(busy), 64'(1));
            end
            if (stall_prev)
                chk("hold_stable", 64'({axis.m_tdata, axis.m_tkeep, axis.m_tlast, axis.m_tvalid}),
                    64'({stall_val, 1'b1}));
            if (last_prev || done) chk("done_pulse", 64'(done), 64'(last_prev));
            hs = axis.m_tvalid && axis.m_tready;
            if (hs) got.push_back('{axis.m_tdata, axis.m_tkeep, axis.m_tlast});
            last_prev  = hs && axis.m_tlast;
            stall_prev = axis.m_tvalid && !axis.m_tready;
            stall_val  = '{axis.m_tdata, axis.m_tkeep, axis.m_tlast};
        end
    end

    task automatic push_one(input logic [7:0] b);
        push_en   = 1'b1;
        push_byte = b;
        step();
        push_en   = 1'b0;
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) push_one(start + 8'(i));
    endtask

    // Reference: chop the byte list into 4-byte LE words, bursts of up to BW
    // words; a burst ends when full or when the bytes run out.
    task automatic build_exp(input logic [7:0] bytes[$], output beat_t exp[$]);
        int i = 0;
        int wc = 0;
        int n = bytes.size();
        exp = {};
        while (i < n) begin
            beat_t w;
            int k = (n - i < 4) ? (n - i) : 4;
            w.data = 32'd0;
            w.keep = 4'd0;
            for (int j = 0; j < k; j++) begin
                w.data = w.data | (32'(bytes[i + j]) << (8 * j));
                w.keep = w.keep | 4'(1 << j);
            end
            i += k;
            wc++;
            w.last = (i == n) || (wc == BW);
            if (w.last) wc = 0;
            exp.push_back(w);
        end
    endtask

    task automatic compare(input string tag, input beat_t exp[$], input int base);
        chk({tag, "_words"}, 64'(got.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (base + i < got.size()) chk({tag, "_beat"}, 64'(got[base + i]), 64'(exp[i]));
    endtask

    // Hold a trigger until the FIFO is drained, with random back-pressure.
    task automatic drain(input string tag, input bit use_ovr, input int rdy_pct);
        beat_t exp[$];
        int base = got.size();
        int n = 0;
        build_exp(fifo_q, exp);
        if (use_ovr) fifo_overrun = 1'b1;
        else fifo_tout = 1'b1;
        repeat (4) begin
            axis.m_tready = ($urandom_range(99) < rdy_pct);
            step();
        end
        while ((fifo_cnt != 0 || busy) && n < 3000) begin
            axis.m_tready = ($urandom_range(99) < rdy_pct);
            step();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < 3000), 64'(1));
        fifo_overrun  = 1'b0;
        fifo_tout     = 1'b0;
        axis.m_tready = 1'b1;
        repeat (6) step();
        compare(tag, exp, base);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!axis.m_tvalid && n < 200) begin
            step();
            n++;
        end
        chk(tag, 64'(axis.m_tvalid), 64'(1));
    endtask

    initial begin
        int base;
        int n;
        logic seen;
        beat_t exp[$];

        resetn = 1'b0; en = 1'b0; fifo_overrun = 1'b0; fifo_tout = 1'b0;
        axis.m_tready = 1'b1;
        #2;
        chk("rst_outputs", 64'({axis.m_tdata, axis.m_tkeep, axis.m_tlast, axis.m_tvalid,
                                fifo_rinc, busy, done}), 64'(0));
        repeat (3) step();
        resetn = 1'b1;
        en = 1'b1;
        step();

        // 8 bytes, timeout trigger
        push_seq(8'h01, 8);
        base = got.size();
        drain("a", 1'b0, 100);
        if (got.size() >= base + 2) begin
            chk("a_w0", 64'(got[base]), 64'({32'h04030201, 4'hF, 1'b0}));
            chk("a_w1", 64'(got[base + 1]), 64'({32'h08070605, 4'hF, 1'b1}));
        end

        // 6 bytes: one full word then a 2-byte partial word
        push_seq(8'hA0, 6);
        base = got.size();
        drain("b", 1'b0, 100);
        if (got.size() >= base + 2) begin
            chk("b_w0", 64'(got[base]), 64'({32'hA3A2A1A0, 4'hF, 1'b0}));
            chk("b_w1", 64'(got[base + 1]), 64'({32'h0000A5A4, 4'h3, 1'b1}));
        end

        // 12 bytes, overrun held: burst of 2 then a second burst of 1
        push_seq(8'h40, 12);
        drain("c", 1'b1, 100);

        // back-pressure: ready low for 10 cycles while a word waits
        push_seq(8'h11, 4);
        axis.m_tready = 1'b0;
        fifo_tout = 1'b1;
        wait_valid("d_valid_timeout");
        fifo_tout = 1'b0;
        n = got.size();
        repeat (10) step();
        chk("d_no_accept", 64'(got.size()), 64'(n));
        axis.m_tready = 1'b1;
        step();
        chk("d_accept", 64'(got.size()), 64'(n + 1));
        if (got.size() > n) chk("d_word", 64'(got[n]), 64'({32'h14131211, 4'hF, 1'b1}));
        repeat (4) step();

        // trigger while empty: must stay idle
        seen = 1'b0;
        fifo_tout = 1'b1;
        repeat (12) begin
            step();
            if (busy || fifo_rinc) seen = 1'b1;
        end
        fifo_tout = 1'b0;
        chk("empty_stays_idle", 64'(seen), 64'(0));

        // reset during a stalled SEND
        push_seq(8'h31, 8);
        axis.m_tready = 1'b0;
        fifo_overrun = 1'b1;
        wait_valid("f_valid_timeout");
        fifo_overrun = 1'b0;
        repeat (5) step();
        resetn = 1'b0;
        #1;
        chk("f_rst_outputs", 64'({axis.m_tdata, axis.m_tkeep, axis.m_tlast, axis.m_tvalid,
                                  fifo_rinc, busy, done}), 64'(0));
        step();
        #2;
        resetn = 1'b1;
        axis.m_tready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (busy || done) seen = 1'b1;
        end
        chk("f_needs_trigger", 64'(seen), 64'(0));
        drain("f_rest", 1'b1, 100);

        // en dropped after the first word: burst still completes
        push_seq(8'h51, 8);
        build_exp(fifo_q, exp);
        base = got.size();
        fifo_tout = 1'b1;
        n = 0;
        while (got.size() == base && n < 200) begin
            step();
            n++;
        end
        en = 1'b0;
        fifo_tout = 1'b0;
        n = 0;
        while ((busy || fifo_cnt != 0) && n < 200) begin
            step();
            n++;
        end
        repeat (3) step();
        compare("g", exp, base);

        // trigger with en low is ignored
        push_seq(8'h61, 4);
        seen = 1'b0;
        fifo_tout = 1'b1;
        repeat (12) begin
            step();
            if (busy || fifo_rinc) seen = 1'b1;
        end
        fifo_tout = 1'b0;
        chk("g_en_low_ignored", 64'(seen), 64'(0));
        en = 1'b1;
        drain("g_rest", 1'b0, 100);

        // randomized bursts with random back-pressure
        for (int r = 0; r < 10; r++) begin
            int nb = $urandom_range(13, 1);
            for (int i = 0; i < nb; i++) push_one(8'($urandom_range(255)));
            drain("rnd", r[0], $urandom_range(100, 30));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 16, meaning the maximum number of 32-bit words per burst (legal range 1..256).
REQ-002 SHALL have parameter FIFO_WIDTH, default 8, meaning the FIFO byte width; only the value 8 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock (the FIFO read clock).
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, drain enable.
REQ-006 SHALL have port fifo_rinc, output, 1, FIFO read enable.
REQ-007 SHALL have port fifo_rdata, input, 8, FIFO read data, registered, valid the cycle after an accepted read.
REQ-008 SHALL have port fifo_rempty, input, 1, FIFO empty flag (clk domain).
REQ-009 SHALL have port fifo_overrun, input, 1, FIFO overrun level (write-clock domain, asynchronous to clk).
REQ-010 SHALL have port fifo_tout, input, 1, FIFO write-idle timeout level (write-clock domain, asynchronous to clk).
REQ-011 SHALL have ports m_tdata (output, 32), m_tkeep (output, 4), m_tlast (output, 1) and m_tvalid (output, 1), forming the stream master.
REQ-012 SHALL have port m_tready, input, 1, stream ready.
REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at burst end.

Function
REQ-015 SHALL pass fifo_overrun and fifo_tout through separate 2-flop synchronizers (ovr_s, tout_s), each reset to 0.
REQ-016 SHALL implement the FSM states IDLE, READ, CAP and SEND.
REQ-017 IDLE SHALL go to READ when en && !fifo_rempty && (ovr_s || tout_s).
- Entering READ SHALL clear byte_idx (2 bits) and word_cnt (8 bits).
REQ-018 READ with !fifo_rempty SHALL assert fifo_rinc for exactly one cycle and go to CAP.
- fifo_rinc SHALL never be asserted in any other state.
- fifo_rinc SHALL never be asserted while fifo_rempty=1.
REQ-019 CAP SHALL store fifo_rdata into byte lane byte_idx, where lane 0 = m_tdata[7:0] (little-endian), and set the corresponding m_tkeep bit.
REQ-020 In CAP, if byte_idx==3, the FSM SHALL go to SEND with m_tlast = (word_cnt==BURST_WORDS-1) || fifo_rempty, sampled in that CAP cycle.
- Otherwise byte_idx SHALL increment and the FSM SHALL return to READ.
REQ-021 READ with fifo_rempty and byte_idx>0 SHALL go to SEND with the partial word: unfilled lanes zero, their m_tkeep bits 0, m_tlast=1.
REQ-022 READ with fifo_rempty and byte_idx==0 SHALL return to IDLE with no output and no done pulse (burst start only).
REQ-023 SEND SHALL assert m_tvalid and hold m_tdata, m_tkeep and m_tlast stable until m_tvalid && m_tready.
REQ-024 On handshake in SEND:
- if m_tlast=1: go to IDLE and pulse done the next cycle;
- otherwise: increment word_cnt, clear the lanes, m_tkeep and byte_idx, and go to READ.
REQ-025 en deasserted mid-burst SHALL NOT abort the burst; en is sampled only in IDLE.
REQ-026 Throughput SHALL be 2 cycles per byte plus at least 1 SEND cycle per word; latency from trigger to the first fifo_rinc SHALL be 1 cycle after IDLE sees the trigger.
REQ-027 word_cnt SHALL never exceed BURST_WORDS-1, and no burst SHALL carry more than BURST_WORDS words.

Reset
REQ-028 resetn low SHALL asynchronously force:
- state=IDLE; byte_idx=0; word_cnt=0;
- m_tdata=0, m_tkeep=0, m_tlast=0, m_tvalid=0;
- fifo_rinc=0, busy=0, done=0;
- both synchronizers = 0.
REQ-029 Reset mid-SEND SHALL drop m_tvalid immediately, discard the partial word, and issue no done pulse.
REQ-030 After reset release, the block SHALL require a fresh synchronized trigger before starting.

Verification
REQ-031 FIFO holds 8 bytes 0x01..0x08, tout pulses, m_tready=1 -> 2 words 0x04030201 and 0x08070605, tkeep=0xF, tlast on word 2, done 1 cycle later.
REQ-032 FIFO holds 6 bytes 0xA0..0xA5, tout -> word 0xA3A2A1A0 (keep 0xF, tlast 0), then 0x0000A5A4 (keep 0x3, tlast 1).
REQ-033 BURST_WORDS=2, 12 bytes, overrun held -> burst 1 is 2 words ending in tlast; a new burst then starts with no en toggle and drains the remaining word.
REQ-034 m_tready held low 10 cycles during SEND -> tdata/tkeep/tlast stable, no fifo_rinc, word accepted on the first ready cycle.
REQ-035 Trigger while fifo_rempty=1 -> the FSM stays in IDLE and fifo_rinc never asserts; resetn pulsed low mid-burst -> all outputs 0 within the same cycle.
REQ-036 en dropped after the first word -> the burst completes normally; a later trigger with en=0 is ignored.
